// File: rtl/duck_round_ctrl.sv
// Purpose : round/duck sequencer for the duck-hunt game: spawns ducks, times their flight,
//           tallies hits, advances rounds and ends the game.
// Latency : every output is a flop; responses appear one clk after the causing input/state.
// Backpressure: none; spawning stalls in SPAWN until hunt_start is high.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   start                    UI start level (rising edge acts, only in IDLE/GAME_OVER)
//   hunt_start               shooting logic is ready to hunt
//   duck_killed              one-cycle hit pulse
//   bullets_left[5:0]        remaining ammunition
//   game_enable, game_over   game status
//   duck_spawn, duck_escaped one-cycle event pulses
//   round_num, ducks_left, round_hits, speed_level   round status for display/speed
//
// Build option: define DUCK_ESCAPE_TIMER_EN to build the escape timer; without it ducks only
// leave FLYING when hit and duck_escaped is tied low.
module duck_round_ctrl #(
    parameter int unsigned DUCKS_PER_ROUND = 10,
    parameter int unsigned PASS_HITS       = 6,
    parameter logic [31:0] ESCAPE_CYCLES   = 32'd325_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       hunt_start,
    input  logic       duck_killed,
    input  logic [5:0] bullets_left,
    output logic       game_enable,
    output logic       duck_spawn,
    output logic       duck_escaped,
    output logic [3:0] round_num,
    output logic [3:0] ducks_left,
    output logic [3:0] round_hits,
    output logic [2:0] speed_level,
    output logic       game_over
);

    if (DUCKS_PER_ROUND < 1 || DUCKS_PER_ROUND > 15 ||
        PASS_HITS < 1 || PASS_HITS > DUCKS_PER_ROUND ||
        ESCAPE_CYCLES == 32'd0) begin : g_param_check
        $error("duck_round_ctrl: parameter out of legal range");
    end

    localparam logic [3:0] DUCKS_INIT = 4'(DUCKS_PER_ROUND);
    localparam logic [3:0] PASS_MIN   = 4'(PASS_HITS);
    localparam logic [3:0] ROUND_MAX  = 4'd15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SPAWN,
        S_FLYING,
        S_NEXT,
        S_ROUND_END,
        S_GAME_OVER
    } state_t;

    state_t     state_q, state_d;
    logic       start_q, start_d;
    logic       start_armed_q, start_armed_d;
    logic       game_enable_q, game_enable_d;
    logic       duck_spawn_q, duck_spawn_d;
    logic [3:0] round_num_q, round_num_d;
    logic [3:0] ducks_left_q, ducks_left_d;
    logic [3:0] round_hits_q, round_hits_d;
    logic [2:0] speed_level_q, speed_level_d;
    logic       game_over_q, game_over_d;
    logic [3:0] round_next;
    logic       start_edge;

`ifdef DUCK_ESCAPE_TIMER_EN
    logic        duck_escaped_q, duck_escaped_d;
    logic [31:0] escape_timer_q, escape_timer_d;
`endif

    // Speed tracks the round number but tops out at 7.
    function automatic logic [2:0] speed_for(input logic [3:0] rnd);
        if (rnd >= 4'd8) begin
            return 3'd7;
        end
        return 3'(rnd - 4'd1);
    endfunction

    // start_armed_q is low for the first cycle after reset so that a start level held
    // through reset release is absorbed into start_q instead of looking like an edge.
    assign start_edge = start & ~start_q & start_armed_q;

    always_comb begin
        state_d       = state_q;
        start_d       = start;
        start_armed_d = 1'b1;
        game_enable_d = game_enable_q;
        duck_spawn_d  = 1'b0;
        round_num_d   = round_num_q;
        ducks_left_d  = ducks_left_q;
        round_hits_d  = round_hits_q;
        speed_level_d = speed_level_q;
        game_over_d   = game_over_q;
        round_next    = round_num_q;
`ifdef DUCK_ESCAPE_TIMER_EN
        duck_escaped_d = 1'b0;
        escape_timer_d = escape_timer_q;
`endif

        unique case (state_q)
            S_IDLE, S_GAME_OVER: begin
                if (start_edge) begin
                    state_d       = S_SPAWN;
                    round_num_d   = 4'd1;
                    ducks_left_d  = DUCKS_INIT;
                    round_hits_d  = 4'd0;
                    speed_level_d = 3'd0;
                    game_enable_d = 1'b1;
                    game_over_d   = 1'b0;
                end
            end

            S_SPAWN: begin
                if (hunt_start) begin
                    duck_spawn_d = 1'b1;
`ifdef DUCK_ESCAPE_TIMER_EN
                    // Loaded with N-1 so the escape pulse lands N cycles after the spawn pulse.
                    escape_timer_d = ESCAPE_CYCLES - 32'd1;
`endif
                    state_d = S_FLYING;
                end
            end

            S_FLYING: begin
                // A hit takes priority over a simultaneous timeout.
                if (duck_killed) begin
                    if (round_hits_q != 4'd15) begin
                        round_hits_d = round_hits_q + 4'd1;
                    end
                    if (ducks_left_q != 4'd0) begin
                        ducks_left_d = ducks_left_q - 4'd1;
                    end
                    state_d = S_NEXT;
                end
`ifdef DUCK_ESCAPE_TIMER_EN
                else if (escape_timer_q == 32'd0) begin
                    duck_escaped_d = 1'b1;
                    if (ducks_left_q != 4'd0) begin
                        ducks_left_d = ducks_left_q - 4'd1;
                    end
                    state_d = S_NEXT;
                end else begin
                    escape_timer_d = escape_timer_q - 32'd1;
                end
`endif
            end

            S_NEXT: begin
                if (bullets_left == 6'd0) begin
                    state_d       = S_GAME_OVER;
                    game_enable_d = 1'b0;
                    game_over_d   = 1'b1;
                end else if (ducks_left_q == 4'd0) begin
                    state_d = S_ROUND_END;
                end else begin
                    state_d = S_SPAWN;
                end
            end

            S_ROUND_END: begin
                if (round_hits_q >= PASS_MIN) begin
                    if (round_num_q != ROUND_MAX) begin
                        round_next = round_num_q + 4'd1;
                    end
                    round_num_d   = round_next;
                    speed_level_d = speed_for(round_next);
                    ducks_left_d  = DUCKS_INIT;
                    round_hits_d  = 4'd0;
                    state_d       = S_SPAWN;
                end else begin
                    // round_num and round_hits stay as they are for the score display.
                    state_d       = S_GAME_OVER;
                    game_enable_d = 1'b0;
                    game_over_d   = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            start_q       <= 1'b0;
            start_armed_q <= 1'b0;
            game_enable_q <= 1'b0;
            duck_spawn_q  <= 1'b0;
            round_num_q   <= 4'd1;
            ducks_left_q  <= DUCKS_INIT;
            round_hits_q  <= 4'd0;
            speed_level_q <= 3'd0;
            game_over_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            start_q       <= start_d;
            start_armed_q <= start_armed_d;
            game_enable_q <= game_enable_d;
            duck_spawn_q  <= duck_spawn_d;
            round_num_q   <= round_num_d;
            ducks_left_q  <= ducks_left_d;
            round_hits_q  <= round_hits_d;
            speed_level_q <= speed_level_d;
            game_over_q   <= game_over_d;
        end
    end

`ifdef DUCK_ESCAPE_TIMER_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            duck_escaped_q <= 1'b0;
            escape_timer_q <= 32'd0;
        end else begin
            duck_escaped_q <= duck_escaped_d;
            escape_timer_q <= escape_timer_d;
        end
    end

    assign duck_escaped = duck_escaped_q;
`else
    assign duck_escaped = 1'b0;
`endif

    assign game_enable = game_enable_q;
    assign duck_spawn  = duck_spawn_q;
    assign round_num   = round_num_q;
    assign ducks_left  = ducks_left_q;
    assign round_hits  = round_hits_q;
    assign speed_level = speed_level_q;
    assign game_over   = game_over_q;

endmodule

// File: doc/duck_round_ctrl.md
DUCK_ROUND_CTRL -- requirements
Module: duck_round_ctrl

Interface
REQ-001 Parameter DUCKS_PER_ROUND, default 10: ducks per round, legal range 1..15.
REQ-002 Parameter PASS_HITS, default 6: minimum hits to advance a round, legal range 1..DUCKS_PER_ROUND.
REQ-003 Parameter ESCAPE_CYCLES, default 325_000_000: duck flight time in clk cycles (5 s at 65 MHz), legal range 1..2^32-1.
REQ-004 clk  in  1  posedge clock; the only clock.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  level from the UI; only its rising edge acts.
REQ-007 hunt_start  in  1  high while the shooting logic is in its hunting phase.
REQ-008 duck_killed  in  1  one-cycle hit pulse from the shooting logic.
REQ-009 bullets_left  in  6  remaining ammunition total.
REQ-010 game_enable  out  1  enables the shooting logic.
REQ-011 duck_spawn  out  1  one-cycle pulse that launches a new duck.
REQ-012 duck_escaped  out  1  one-cycle pulse when a duck flies away unhit.
REQ-013 round_num  out  4  current round, 1..15.
REQ-014 ducks_left  out  4  ducks not yet resolved in this round.
REQ-015 round_hits  out  4  hits scored in this round.
REQ-016 speed_level  out  3  flight speed selector, equal to min(round_num-1, 7).
REQ-017 game_over  out  1  high while in GAME_OVER.

Function
REQ-018 States SHALL be IDLE, SPAWN, FLYING, NEXT, ROUND_END and GAME_OVER; all outputs SHALL be registered.
REQ-019 A start rising edge SHALL be detected against a registered copy of start.
REQ-020 IDLE or GAME_OVER, on a start edge: go to SPAWN and set round_num=1, ducks_left=DUCKS_PER_ROUND, round_hits=0, speed_level=0, game_enable=1, game_over=0.
REQ-021 SPAWN: wait while hunt_start=0; on the first cycle with hunt_start=1, pulse duck_spawn for one cycle, load the escape timer with ESCAPE_CYCLES-1, and go to FLYING.
REQ-022 FLYING, duck_killed=1: increment round_hits (saturating at 15), decrement ducks_left, and go to NEXT.
REQ-023 FLYING, escape timer at 0 with no kill: pulse duck_escaped, decrement ducks_left, and go to NEXT.
REQ-024 If a kill and the escape timeout occur in the same cycle, the kill SHALL win and duck_escaped SHALL stay 0.
REQ-025 While in FLYING, the escape timer SHALL decrement by 1 per cycle and SHALL NOT wrap below 0.
REQ-026 NEXT, in priority order: bullets_left=0 goes to GAME_OVER; ducks_left=0 goes to ROUND_END; otherwise go to SPAWN.
REQ-027 A kill with the last bullet (duck_killed=1 and bullets_left=0 in the same cycle) SHALL count the hit first, then end the game in NEXT.
REQ-028 ROUND_END, round_hits>=PASS_HITS: round_num+1 (saturating at 15), speed_level=min(new round_num-1, 7), ducks_left=DUCKS_PER_ROUND, round_hits=0, then go to SPAWN.
REQ-029 ROUND_END, round_hits<PASS_HITS: go to GAME_OVER.
REQ-030 GAME_OVER: game_enable=0 and game_over=1; round_num and round_hits SHALL be held for display.
REQ-031 duck_killed pulses outside FLYING SHALL be ignored.
REQ-032 A start edge in any state other than IDLE or GAME_OVER SHALL be ignored.
REQ-033 duck_spawn and duck_escaped SHALL never be high in the same cycle.

Reset
REQ-034 When rst=1 at a clk edge, the next state SHALL be IDLE from any state, including mid-flight.
REQ-035 Reset values: game_enable=0, duck_spawn=0, duck_escaped=0, round_num=1, ducks_left=DUCKS_PER_ROUND, round_hits=0, speed_level=0, game_over=0, escape timer=0, start history=0.
REQ-036 A start held high through reset release SHALL NOT produce a start edge.

Configuration
REQ-037 With macro DUCK_ESCAPE_TIMER_EN defined, the escape timer and the duck_escaped behaviour SHALL be as specified in REQ-021..REQ-025.
REQ-038 Without DUCK_ESCAPE_TIMER_EN, no escape timer SHALL be built, duck_escaped SHALL be tied to 0, and FLYING SHALL leave only on duck_killed.

Verification
REQ-039 Reset, then start rising edge, then hunt_start=1 -> game_enable=1 next cycle; one duck_spawn pulse; round_num=1; ducks_left=10.
REQ-040 With ESCAPE_CYCLES=20 and the macro defined, spawn then no kill -> duck_escaped pulses exactly 20 cycles after duck_spawn; ducks_left=9; round_hits=0.
REQ-041 10 ducks with 6 kills -> round_num=2, speed_level=1, ducks_left=10, round_hits=0; 10 ducks with 5 kills -> game_over=1, game_enable=0, round_hits=5.
REQ-042 duck_killed and timer=0 in the same cycle -> round_hits increments and duck_escaped stays 0; duck_killed with bullets_left=0 -> round_hits increments, then game_over=1.
REQ-043 rst asserted mid-FLYING -> all outputs at reset values next cycle; start held high through reset release -> stays in IDLE.
REQ-044 Run 15 passing rounds -> round_num saturates at 15 and speed_level at 7; start edge in GAME_OVER -> round_num=1 and game_enable=1.
